sp_fifo_ptr_ctl: RTL
====================

SP_FIFO_PTR_CTL -- requirements
Module: sp_fifo_ptr_ctl

Interface
REQ-001 SHALL have parameter: WIDTH, default `WIDTH, RAM address width; FIFO depth = 2^WIDTH words.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: push  input  1  write request from producer.
REQ-005 SHALL have port: din  input  32  write data from producer.
REQ-006 SHALL have port: full  output  1  no free entry.
REQ-007 SHALL have port: pop  input  1  read request from consumer.
REQ-008 SHALL have port: empty  output  1  no committed (readable) entry.
REQ-009 SHALL have port: count  output  WIDTH+1  occupied entries, committed or not.
REQ-010 SHALL have port: dout  output  32  read data; meaningful only while dout_valid=1.
REQ-011 SHALL have port: dout_valid  output  1  one-cycle read-data strobe.
REQ-012 SHALL have port: WE_N  output  1  write strobe to bank controller, active-high.
REQ-013 SHALL have port: RE_N  output  1  read strobe to bank controller, active-high.
REQ-014 SHALL have port: W_ADR  output  WIDTH  write address; LSB selects bank.
REQ-015 SHALL have port: R_ADR  output  WIDTH  read address; LSB selects bank.
REQ-016 SHALL have port: DI  output  32  write data to bank controller.
REQ-017 SHALL have port: DO_0  input  32  bank-0 RAM read data, one-cycle latency.
REQ-018 SHALL have port: DO_1  input  32  bank-1 RAM read data, one-cycle latency.

Function
REQ-019 SHALL keep wr_ptr and rd_ptr, each WIDTH+1 bits (MSB = wrap bit), incrementing modulo 2^(WIDTH+1).
REQ-020 SHALL accept a push when push=1 and full=0; accepted push: WE_N=1, W_ADR=wr_ptr[WIDTH-1:0], DI=din, same cycle (combinational); wr_ptr+1 at edge.
REQ-021 SHALL accept a pop when pop=1 and empty=0; accepted pop: RE_N=1, R_ADR=rd_ptr[WIDTH-1:0], same cycle; rd_ptr+1 at edge.
REQ-022 SHALL drive WE_N=0 / RE_N=0 when not accepted; W_ADR/R_ADR still show current pointers, DI=din.
REQ-023 SHALL compute count = wr_ptr - rd_ptr (WIDTH+1 bits); full = (count == 2^WIDTH).
REQ-024 SHALL keep wr_ptr_c, a copy of wr_ptr registered one cycle later; empty = (wr_ptr_c == rd_ptr).
REQ-025 SHALL thereby make a word pushed in cycle t poppable no earlier than cycle t+2, covering the bank controller's one-cycle deferred write on same-bank conflict.
REQ-026 SHALL register accepted-pop and R_ADR[0]; in the next cycle dout_valid=1 and dout = DO_1 if registered bit=1 else DO_0.
REQ-027 SHALL sustain one push and one pop per cycle indefinitely (no bubbles) when neither flag blocks.
REQ-028 SHALL evaluate full/empty from pre-edge state: push while full rejected even with simultaneous pop; pop while empty rejected even with simultaneous push.
REQ-029 SHALL deassert full the cycle after an accepted pop; deassert empty two cycles after the first accepted push into an empty FIFO.
REQ-030 SHALL wrap addresses from 2^WIDTH-1 to 0 with wrap bit toggling; full/empty remain correct across wrap.
REQ-031 SHALL never issue the same address for write and read in one cycle while count>0 (guaranteed by REQ-024).

Reset
REQ-032 SHALL, on rising clk with rst=0, clear wr_ptr, rd_ptr, wr_ptr_c, registered read bank and dout_valid to 0.
REQ-033 SHALL present after reset: empty=1, full=0, count=0, dout_valid=0, WE_N=0, RE_N=0.
REQ-034 SHALL ignore push/pop in any cycle where rst=0; in-flight dout_valid is dropped; reset mid-stream discards all contents.

Verification (WIDTH=4, depth 16)
REQ-035 SHALL check: reset, push din=32'hA5A50001 in cycle 1 -> WE_N=1, W_ADR=0, DI=32'hA5A50001; empty=1 in cycle 2, empty=0 in cycle 3; count=1 from cycle 2.
REQ-036 SHALL check: 16 consecutive pushes -> full=1, count=16; 17th push -> WE_N=0, count stays 16; push+pop while full -> RE_N=1, WE_N=0, full=0 next cycle.
REQ-037 SHALL check: pop on empty FIFO (also with simultaneous push) -> RE_N=0, no dout_valid pulse, rd_ptr unchanged.
REQ-038 SHALL check: pop with R_ADR=5, next cycle DO_1=32'h12345678, DO_0=32'hDEADBEEF -> dout=32'h12345678, dout_valid=1 for exactly one cycle.
REQ-039 SHALL check: 40 cycles of simultaneous push/pop at count=3 -> count constant 3, W_ADR sequence ...14,15,0,1..., data out in push order.
REQ-040 SHALL check: rst=0 for one edge with count=9 and a pop in flight -> next cycle count=0, empty=1, full=0, dout_valid=0.

Source files
------------

// File: rtl/sp_fifo_ptr_ctl_if.sv
// Bundle of producer, consumer and bank-controller signals around the FIFO
// pointer controller. The slave side is the controller; the master side is
// everything around it (producer, consumer and the two-bank RAM controller).
`ifndef WIDTH
`define WIDTH 4
`endif

interface sp_fifo_ptr_ctl_if #(
  parameter int WIDTH = `WIDTH
);
  // producer side
  logic              push;
  logic [31:0]       din;
  logic              full;
  // consumer side
  logic              pop;
  logic              empty;
  logic [WIDTH:0]    count;
  logic [31:0]       dout;
  logic              dout_valid;
  // bank controller side (strobes are active-high despite their names)
  logic              WE_N;
  logic              RE_N;
  logic [WIDTH-1:0]  W_ADR;
  logic [WIDTH-1:0]  R_ADR;
  logic [31:0]       DI;
  logic [31:0]       DO_0;
  logic [31:0]       DO_1;

  modport master (
    output push, din, pop, DO_0, DO_1,
    input  full, empty, count, dout, dout_valid,
    input  WE_N, RE_N, W_ADR, R_ADR, DI
  );

  modport slave (
    input  push, din, pop, DO_0, DO_1,
    output full, empty, count, dout, dout_valid,
    output WE_N, RE_N, W_ADR, R_ADR, DI
  );
endinterface

// File: rtl/sp_fifo_ptr_ctl.sv
// Pointer controller for a FIFO stored in a two-bank RAM (address LSB picks
// the bank). Writes and reads are issued combinationally in the request
// cycle; read data comes back from the banks one cycle later. Emptiness is
// judged against a one-cycle-delayed write pointer so a word is never read
// before a deferred same-bank write has landed in the RAM.
`ifndef WIDTH
`define WIDTH 4
`endif

module sp_fifo_ptr_ctl #(
  parameter int WIDTH = `WIDTH
) (
  input logic              clk,
  input logic              rst,
  sp_fifo_ptr_ctl_if.slave bus
);

  localparam int PW = WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {WIDTH{1'b0}}};

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_c;
  logic [PW-1:0] occ;
  logic          full_i;
  logic          empty_i;
  logic          push_ok;
  logic          pop_ok;
  logic          rd_bank;
  logic          rd_vld;

  // Flags, acceptance and the combinational bank-controller strobes.
  always_comb begin
    // NOTE: every signal written here is assigned unconditionally, so no
    // path through the block leaves a value held and no latch is inferred.
    occ     = wr_ptr - rd_ptr;
    full_i  = (occ == DEPTH);
    empty_i = (wr_ptr_c == rd_ptr);
    // Requests are ignored while reset is asserted; flags come from
    // pre-edge state, so a simultaneous pop never unblocks a push.
    push_ok = rst & bus.push & ~full_i;
    pop_ok  = rst & bus.pop  & ~empty_i;

    bus.full       = full_i;
    bus.empty      = empty_i;
    bus.count      = occ;
    bus.WE_N       = push_ok;
    bus.RE_N       = pop_ok;
    bus.W_ADR      = wr_ptr[WIDTH-1:0];
    bus.R_ADR      = rd_ptr[WIDTH-1:0];
    bus.DI         = bus.din;
    bus.dout_valid = rd_vld;
    bus.dout       = rd_bank ? bus.DO_1 : bus.DO_0;
  end

  // Pointer advance, delayed write-pointer copy and read-return tracking.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here (synchronous), and all
    // state uses non-blocking assignment so every register sees pre-edge values.
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_ptr_c <= '0;
      rd_bank  <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      wr_ptr_c <= wr_ptr;
      rd_vld   <= pop_ok;
      if (pop_ok) rd_bank <= rd_ptr[0];
    end
  end

endmodule
